// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_pkg
// Purpose  : Shared types and owner codes for the I/D-cache bus arbiter and
//            the system-bus mux that consumes its bus_owner select.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_I    = 2'd1,
    GRANT_D    = 2'd2,
    TURNAROUND = 2'd3
  } arb_state_t;

  // Owner code carried on bus_owner and used as the bus mux select
  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_NONE   = 2'd0;
  localparam owner_t OWNER_ICACHE = 2'd1;
  localparam owner_t OWNER_DCACHE = 2'd2;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Purpose  : Request/idle/grant bundle between the two caches and the bus
//            arbiter. 'master' is the requester view, 'slave' the arbiter view.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic   icache_busreq;
  logic   icache_busidle;
  logic   dcache_busreq;
  logic   dcache_busidle;
  logic   icache_busgrant;
  logic   dcache_busgrant;
  owner_t bus_owner;

  // Requester side: caches drive requests/idle, observe grants
  modport master (
    output icache_busreq, icache_busidle, dcache_busreq, dcache_busidle,
    input  icache_busgrant, dcache_busgrant, bus_owner
  );

  // Arbiter side: samples requests/idle, drives grants and owner select
  modport slave (
    input  icache_busreq, icache_busidle, dcache_busreq, dcache_busidle,
    output icache_busgrant, dcache_busgrant, bus_owner
  );

endinterface : bus_arbiter_if
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-requester (icache/dcache) system-bus arbiter. Round-robin on
//            ties, grant held until the grantee goes busy then idle again, or
//            until an optional never-started timeout expires. A one-cycle
//            TURNAROUND separates consecutive grants. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 16,
  parameter bit TIMEOUT_EN    = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  bus_arbiter_if.slave  arb_bus
);

  localparam int               CNT_W   = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state_q, state_d;
  owner_t           last_owner_q, last_owner_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             icache_grant_q, icache_grant_d;
  logic             dcache_grant_q, dcache_grant_d;
  owner_t           owner_q, owner_d;

  logic             grantee_idle;
  logic [CNT_W-1:0] cnt_inc;

  // Next-state, bookkeeping and registered-output decode
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    started_d    = started_q;
    cnt_d        = cnt_q;

    // Only the current grantee's idle matters; the other one is ignored
    grantee_idle = (state_q == GRANT_I) ? arb_bus.icache_busidle
                                        : arb_bus.dcache_busidle;
    // Saturating increment so the counter can never wrap back to zero
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    case (state_q)
      IDLE: begin
        started_d = 1'b0;
        cnt_d     = '0;
        if (arb_bus.icache_busreq && arb_bus.dcache_busreq) begin
          // Tie: hand the bus to whoever did not have it last
          if (last_owner_q == OWNER_ICACHE) begin
            state_d      = GRANT_D;
            last_owner_d = OWNER_DCACHE;
          end else begin
            state_d      = GRANT_I;
            last_owner_d = OWNER_ICACHE;
          end
        end else if (arb_bus.icache_busreq) begin
          state_d      = GRANT_I;
          last_owner_d = OWNER_ICACHE;
        end else if (arb_bus.dcache_busreq) begin
          state_d      = GRANT_D;
          last_owner_d = OWNER_DCACHE;
        end
      end

      GRANT_I, GRANT_D: begin
        if (started_q && grantee_idle) begin
          // Transaction ran and finished: normal release
          state_d = TURNAROUND;
        end else if (TIMEOUT_EN && !started_q && grantee_idle &&
                     (cnt_inc == CNT_MAX)) begin
          // Grantee never started within the window: revoke
          state_d = TURNAROUND;
        end else begin
          if (!grantee_idle) begin
            started_d = 1'b1;
          end
          if (!started_q) begin
            cnt_d = cnt_inc;
          end
        end
      end

      TURNAROUND: begin
        state_d   = IDLE;
        started_d = 1'b0;
        cnt_d     = '0;
      end

      default: begin
        state_d   = IDLE;
        started_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    icache_grant_d = (state_d == GRANT_I);
    dcache_grant_d = (state_d == GRANT_D);
    owner_d        = (state_d == GRANT_I) ? OWNER_ICACHE :
                     (state_d == GRANT_D) ? OWNER_DCACHE : OWNER_NONE;
  end

  // State, bookkeeping and output registers; reset drops any grant at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_owner_q   <= OWNER_ICACHE;
      started_q      <= 1'b0;
      cnt_q          <= '0;
      icache_grant_q <= 1'b0;
      dcache_grant_q <= 1'b0;
      owner_q        <= OWNER_NONE;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      started_q      <= started_d;
      cnt_q          <= cnt_d;
      icache_grant_q <= icache_grant_d;
      dcache_grant_q <= dcache_grant_d;
      owner_q        <= owner_d;
    end
  end

  assign arb_bus.icache_busgrant = icache_grant_q;
  assign arb_bus.dcache_busgrant = dcache_grant_q;
  assign arb_bus.bus_owner       = owner_q;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter. Vector table plus directed
//            sequences for timeout, no-timeout and mid-grant reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bus_arbiter_if if_a();
  bus_arbiter_if if_b();

  bus_arbiter #(.GRANT_TIMEOUT(16), .TIMEOUT_EN(1'b1)) dut_a (
    .clk     (clk),
    .reset   (rst),
    .arb_bus (if_a.slave)
  );

  bus_arbiter #(.GRANT_TIMEOUT(16), .TIMEOUT_EN(1'b0)) dut_b (
    .clk     (clk),
    .reset   (rst),
    .arb_bus (if_b.slave)
  );

  // One row: inputs held for a cycle, expected state after the next edge
  typedef struct {
    logic       rst;
    logic       ireq;
    logic       iidle;
    logic       dreq;
    logic       didle;
    arb_state_t st;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic ir, input logic ii,
                     input logic dr, input logic di, input arb_state_t st);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iidle = ii; v.dreq = dr; v.didle = di; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs follow from the expected state: grant only in its own
  // GRANT state, owner code matching
  task automatic chk(input string name, input logic ig, input logic dg,
                     input logic [1:0] own, input arb_state_t st,
                     input arb_state_t est);
    logic       eig, edg;
    logic [1:0] eown;
    eig  = (est == GRANT_I);
    edg  = (est == GRANT_D);
    eown = eig ? OWNER_ICACHE : (edg ? OWNER_DCACHE : OWNER_NONE);
    n_vec++;
    if (ig !== eig || dg !== edg || own !== eown || st !== est) begin
      n_err++;
      $display("FAIL %s: got ig=%b dg=%b owner=%0d state=%s, want ig=%b dg=%b owner=%0d state=%s",
               name, ig, dg, own, st.name(), eig, edg, eown, est.name());
    end
  endtask

  task automatic chk_a(input string name, input arb_state_t est);
    chk(name, if_a.icache_busgrant, if_a.dcache_busgrant, if_a.bus_owner,
        dut_a.state_q, est);
  endtask

  task automatic chk_b(input string name, input arb_state_t est);
    chk(name, if_b.icache_busgrant, if_b.dcache_busgrant, if_b.bus_owner,
        dut_b.state_q, est);
  endtask

  // Grants mutually exclusive and owner code consistent, every cycle
  task automatic inv(input string name, input logic ig, input logic dg,
                     input logic [1:0] own);
    logic [1:0] eown;
    eown = ig ? OWNER_ICACHE : (dg ? OWNER_DCACHE : OWNER_NONE);
    if ((ig && dg) || own !== eown) begin
      n_err++;
      $display("FAIL %s: got ig=%b dg=%b owner=%0d, want exclusive grants with owner=%0d",
               name, ig, dg, own, eown);
    end
  endtask

  always @(negedge clk) begin
    inv("invariant_a", if_a.icache_busgrant, if_a.dcache_busgrant, if_a.bus_owner);
    inv("invariant_b", if_b.icache_busgrant, if_b.dcache_busgrant, if_b.bus_owner);
  end

  initial begin
    if_a.icache_busreq = 1'b0; if_a.icache_busidle = 1'b1;
    if_a.dcache_busreq = 1'b0; if_a.dcache_busidle = 1'b1;
    if_b.icache_busreq = 1'b0; if_b.icache_busidle = 1'b1;
    if_b.dcache_busreq = 1'b0; if_b.dcache_busidle = 1'b1;

    //   rst ireq iidle dreq didle  expected state
    add(1, 0, 1, 0, 1, IDLE);          // reset state
    add(0, 0, 1, 0, 1, IDLE);          // no requests: stay idle
    // dcache alone: request in cycle 0, grant in cycle 1
    add(0, 0, 1, 1, 1, GRANT_D);       // cycle 0 -> 1
    add(0, 0, 1, 1, 1, GRANT_D);       // cycle 1 -> 2
    for (int c = 2; c <= 10; c++)
      add(0, 0, 1, 1, 0, GRANT_D);     // busy cycles 2..10
    add(0, 0, 1, 0, 1, TURNAROUND);    // idle at 11 -> grant drops at 12
    add(0, 0, 1, 0, 1, IDLE);          // cycle 13 idle
    // tie after reset: dcache first, then icache, then dcache again
    add(1, 0, 1, 0, 1, IDLE);
    add(0, 1, 1, 1, 1, GRANT_D);       // tie -> dcache
    add(0, 1, 0, 1, 0, GRANT_D);       // started; icache idle ignored
    add(0, 1, 1, 0, 0, GRANT_D);       // busreq drop does not release
    add(0, 1, 0, 0, 0, GRANT_D);
    add(0, 1, 1, 0, 1, TURNAROUND);    // release
    add(0, 1, 1, 0, 1, IDLE);
    add(0, 1, 1, 0, 1, GRANT_I);       // pending icache, 2 cycles after drop
    add(0, 1, 0, 0, 1, GRANT_I);       // started
    add(0, 1, 1, 1, 0, TURNAROUND);    // release and new dreq same cycle
    add(0, 1, 1, 1, 1, IDLE);
    add(0, 1, 1, 1, 1, GRANT_D);       // tie, last was icache -> dcache
    add(0, 0, 1, 0, 0, GRANT_D);
    add(0, 0, 1, 0, 1, TURNAROUND);
    add(0, 0, 1, 0, 1, IDLE);
    add(0, 1, 1, 1, 1, GRANT_I);       // tie, last was dcache -> icache
    add(0, 0, 0, 0, 1, GRANT_I);
    add(0, 0, 1, 0, 1, TURNAROUND);
    add(0, 0, 1, 0, 1, IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      rst                = vecs[i].rst;
      if_a.icache_busreq  = vecs[i].ireq;
      if_a.icache_busidle = vecs[i].iidle;
      if_a.dcache_busreq  = vecs[i].dreq;
      if_a.dcache_busidle = vecs[i].didle;
      tick();
      chk_a($sformatf("vec%0d", i), vecs[i].st);
    end
    rst = 1'b0;

    // Timeout: icache granted at cycle 1, never goes busy, revoked at cycle 17
    if_a.icache_busreq = 1'b1; if_a.icache_busidle = 1'b1;
    tick();
    chk_a("timeout_grant_c1", GRANT_I);
    if_a.icache_busreq = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk_a($sformatf("timeout_hold_c%0d", k), GRANT_I);
    end
    tick();
    chk_a("timeout_revoke_c17", TURNAROUND);
    tick();
    chk_a("timeout_idle_c18", IDLE);

    // Once started, a long transaction is never timed out
    if_a.icache_busreq = 1'b1;
    tick();
    chk_a("long_grant", GRANT_I);
    if_a.icache_busreq = 1'b0; if_a.icache_busidle = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk_a($sformatf("long_hold_%0d", k), GRANT_I);
    end
    if_a.icache_busidle = 1'b1;
    tick();
    chk_a("long_release", TURNAROUND);
    tick();
    chk_a("long_idle", IDLE);

    // Timeout disabled: never-started grant held for 100 cycles
    if_b.icache_busreq = 1'b1; if_b.icache_busidle = 1'b1;
    tick();
    chk_b("noto_grant", GRANT_I);
    if_b.icache_busreq = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk_b($sformatf("noto_hold_%0d", k), GRANT_I);
    end
    if_b.icache_busidle = 1'b0;
    tick();
    chk_b("noto_started", GRANT_I);
    if_b.icache_busidle = 1'b1;
    tick();
    chk_b("noto_release", TURNAROUND);
    tick();
    chk_b("noto_idle", IDLE);

    // Reset in cycle 5 of a dcache grant with icache pending
    if_a.dcache_busreq = 1'b1; if_a.dcache_busidle = 1'b1;
    tick();
    chk_a("rst_grant_c1", GRANT_D);
    if_a.dcache_busidle = 1'b0; if_a.icache_busreq = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk_a($sformatf("rst_hold_c%0d", c), GRANT_D);
    end
    rst = 1'b1;
    tick();
    chk_a("rst_mid_grant", IDLE);
    rst = 1'b0; if_a.dcache_busreq = 1'b0; if_a.dcache_busidle = 1'b1;
    tick();
    chk_a("rst_pending_icache", GRANT_I);
    if_a.icache_busreq = 1'b0; if_a.icache_busidle = 1'b0;
    tick();
    chk_a("rst_icache_busy", GRANT_I);
    if_a.icache_busidle = 1'b1;
    tick();
    chk_a("rst_icache_release", TURNAROUND);
    tick();
    chk_a("rst_icache_idle", IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter GRANT_TIMEOUT, default 16: cycles a grantee may hold grant without deasserting its busidle before grant is revoked.
REQ-002 SHALL have parameter TIMEOUT_EN, default 1: 1 enables the GRANT_TIMEOUT revocation, 0 disables it.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port icache_busreq  input  1  instruction cache requests system bus ownership.
REQ-006 SHALL have port icache_busidle  input  1  instruction cache has no bus transaction in flight.
REQ-007 SHALL have port dcache_busreq  input  1  data cache requests ownership (read fill or dirty writeback).
REQ-008 SHALL have port dcache_busidle  input  1  data cache has no bus transaction in flight.
REQ-009 SHALL have port icache_busgrant  output  1  registered grant to instruction cache.
REQ-010 SHALL have port dcache_busgrant  output  1  registered grant to data cache.
REQ-011 SHALL have port bus_owner  output  2  registered owner code: 0 none, 1 icache, 2 dcache; drives external bus-signal mux select.

Function
REQ-012 SHALL implement states IDLE, GRANT_I, GRANT_D, TURNAROUND.
REQ-013 SHALL hold icache_busgrant=1 only in GRANT_I, dcache_busgrant=1 only in GRANT_D; never both; all outputs registered.
REQ-014 In IDLE with one request asserted, SHALL enter that requester's GRANT state on the next edge (1-cycle request-to-grant latency).
REQ-015 In IDLE with both requests asserted, SHALL grant the requester that was not last_owner (round-robin); last_owner updates on every grant.
REQ-016 In a GRANT state, SHALL set a 1-bit started flag when the grantee's busidle is sampled 0.
REQ-017 In a GRANT state, SHALL release on the edge after the grantee's busidle is sampled 1 with started=1: go to TURNAROUND, grant and bus_owner drop to 0.
REQ-018 Grantee busreq deassertion SHALL NOT release the grant; only REQ-017 or REQ-019 release it.
REQ-019 With TIMEOUT_EN=1, SHALL count cycles in a GRANT state with started=0; at count==GRANT_TIMEOUT, SHALL release as in REQ-017.
REQ-020 Timeout counter SHALL be $clog2(GRANT_TIMEOUT+1) bits, clear on entering a GRANT state, saturate, never wrap.
REQ-021 TURNAROUND SHALL last exactly 1 cycle, then IDLE; no grant is issued in TURNAROUND, giving at least 2 cycles between the end of one grant and the next grant.
REQ-022 Requests arriving while the other requester holds grant SHALL be held pending (requesters keep busreq asserted) and served via REQ-014/REQ-015 after TURNAROUND.
REQ-023 If busidle rises and the other busreq asserts in the same cycle, SHALL process the release first; the new grant follows REQ-021.
REQ-024 Busidle of the non-granted requester SHALL be ignored.

Reset
REQ-025 On reset=1 at a clock edge: state=IDLE, icache_busgrant=0, dcache_busgrant=0, bus_owner=0, started=0, counter=0, last_owner=icache (dcache wins first tie).
REQ-026 Reset asserted mid-grant SHALL drop grant on that same edge; no TURNAROUND is inserted.

Structure
REQ-027 Shared package SHALL hold the arb_state_t enum and owner-code constants OWNER_NONE=0, OWNER_ICACHE=1, OWNER_DCACHE=2, used also by the top-level bus mux.
REQ-028 SHALL be a single module with no sub-modules; counter and FSM inline.

Verification
REQ-029 Reset, then dcache_busreq=1 at cycle 0 -> dcache_busgrant=1, bus_owner=2 at cycle 1; dcache_busidle 0 for cycles 2-10, 1 at 11 -> grant=0 at cycle 12, IDLE at 13.
REQ-030 Both requests asserted in IDLE after reset -> dcache granted first; after its release, icache granted 2 cycles after grant drop; next tie -> dcache.
REQ-031 icache granted, busidle held 1, TIMEOUT_EN=1 -> grant revoked exactly 16 cycles after grant assertion; TIMEOUT_EN=0 -> held indefinitely (check 100 cycles).
REQ-032 dcache granted, drops busreq in cycle 2 while busidle=0 -> grant remains until busidle=1 (REQ-018).
REQ-033 reset pulsed at cycle 5 of a dcache grant -> both grants and bus_owner 0 on that edge, state IDLE; pending icache_busreq granted 1 cycle after reset deasserts.
REQ-034 Assertion over all runs: grants never both 1; bus_owner always consistent with grants.
